// File: rtl/alu_pipe.sv
// Two-stage pipelined WISC ALU with valid/ready handshakes, back-pressure and flush.
// Define ALU_PIPE_OFL_EN to register signed overflow of add/sub/addi/subi on ofl.
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       opcode,
  input  logic [1:0]       funct,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [WIDTH-1:0] pc,
  input  logic [7:0]       imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             br_take,
  output logic             ofl
);

  // ADDC/SUB are the overflow-checked arithmetic ops; ADD is address generation.
  typedef enum logic [4:0] {
    OP_ZERO, OP_ADD, OP_ADDC, OP_SUB, OP_ANDN, OP_XOR,
    OP_ROL, OP_SLL, OP_ROR, OP_SRL, OP_BTR,
    OP_SEQ, OP_SLT, OP_SLE, OP_SCO,
    OP_BNEZ, OP_BEQZ, OP_BLTZ, OP_BGEZ,
    OP_PASSB, OP_SLBI
  } op_e;

  logic             s1_valid, s2_valid, s1_adv, accept;
  op_e              dec_op, s1_op;
  logic [WIDTH-1:0] dec_b, s1_a, s1_b;
  logic [WIDTH-1:0] simm5, zimm5, simm8, zimm8;

  assign s1_adv   = s1_valid && (!s2_valid || out_ready);
  assign in_ready = !s1_valid || s1_adv;
  assign accept   = in_valid && in_ready;

  assign simm5 = {{(WIDTH-5){imm[4]}}, imm[4:0]};
  assign zimm5 = {{(WIDTH-5){1'b0}}, imm[4:0]};
  assign simm8 = {{(WIDTH-8){imm[7]}}, imm};
  assign zimm8 = {{(WIDTH-8){1'b0}}, imm};

  always_comb begin
    dec_op = OP_ZERO;
    dec_b  = rt;
    case (opcode)
      5'b01000: begin dec_op = OP_SUB;  dec_b = simm5; end
      5'b01001: begin dec_op = OP_ADDC; dec_b = simm5; end
      5'b01010: begin dec_op = OP_ANDN; dec_b = zimm5; end
      5'b01011: begin dec_op = OP_XOR;  dec_b = zimm5; end
      5'b10100: begin dec_op = OP_ROL;  dec_b = zimm8; end
      5'b10101: begin dec_op = OP_SLL;  dec_b = zimm8; end
      5'b10110: begin dec_op = OP_ROR;  dec_b = zimm8; end
      5'b10111: begin dec_op = OP_SRL;  dec_b = zimm8; end
      5'b11010:
        case (funct)
          2'b00:   dec_op = OP_ROL;
          2'b01:   dec_op = OP_SLL;
          2'b10:   dec_op = OP_ROR;
          default: dec_op = OP_SRL;
        endcase
      5'b11011:
        case (funct)
          2'b00:   dec_op = OP_ADDC;
          2'b01:   dec_op = OP_SUB;
          2'b10:   dec_op = OP_XOR;
          default: dec_op = OP_ANDN;
        endcase
      5'b10000, 5'b10001, 5'b10011: begin dec_op = OP_ADD; dec_b = simm5; end
      5'b11001: dec_op = OP_BTR;
      5'b11100: dec_op = OP_SEQ;
      5'b11101: dec_op = OP_SLT;
      5'b11110: dec_op = OP_SLE;
      5'b11111: dec_op = OP_SCO;
      5'b01100: dec_op = OP_BNEZ;
      5'b01101: dec_op = OP_BEQZ;
      5'b01110: dec_op = OP_BLTZ;
      5'b01111: dec_op = OP_BGEZ;
      5'b11000: begin dec_op = OP_PASSB; dec_b = simm8; end
      5'b10010: begin dec_op = OP_SLBI;  dec_b = zimm8; end
      5'b00110, 5'b00111, 5'b00101, 5'b00100: begin dec_op = OP_PASSB; dec_b = pc; end
      default:  dec_op = OP_ZERO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_op    <= dec_op;
      s1_a     <= rs;
      s1_b     <= dec_b;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Execute: operand b already carries rt, the extended immediate or pc.
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] dif, rev, rol_r, ror_r, res_nxt;
  logic [SHW-1:0]   amt;
  logic [SHW:0]     lamt;
  logic             flag, br_nxt;

  assign sum   = {1'b0, s1_a} + {1'b0, s1_b};
  assign dif   = s1_b - s1_a;
  assign amt   = s1_b[SHW-1:0];
  assign lamt  = (SHW+1)'(WIDTH) - {1'b0, amt};
  assign ror_r = WIDTH'({s1_a, s1_a} >> amt);
  assign rol_r = WIDTH'({s1_a, s1_a} >> lamt);

  always_comb begin
    for (int i = 0; i < WIDTH; i++) rev[i] = s1_a[WIDTH-1-i];
  end

  always_comb begin
    res_nxt = '0;
    flag    = 1'b0;
    br_nxt  = 1'b0;
    case (s1_op)
      OP_ADD, OP_ADDC: res_nxt = sum[WIDTH-1:0];
      OP_SUB:   res_nxt = dif;
      OP_ANDN:  res_nxt = s1_a & ~s1_b;
      OP_XOR:   res_nxt = s1_a ^ s1_b;
      OP_ROL:   res_nxt = rol_r;
      OP_SLL:   res_nxt = s1_a << amt;
      OP_ROR:   res_nxt = ror_r;
      OP_SRL:   res_nxt = s1_a >> amt;
      OP_BTR:   res_nxt = rev;
      OP_SEQ:   flag = (s1_a == s1_b);
      OP_SLT:   flag = ($signed(s1_a) <  $signed(s1_b));
      OP_SLE:   flag = ($signed(s1_a) <= $signed(s1_b));
      OP_SCO:   flag = sum[WIDTH];
      OP_BNEZ:  begin flag = (s1_a != '0);     br_nxt = flag; end
      OP_BEQZ:  begin flag = (s1_a == '0);     br_nxt = flag; end
      OP_BLTZ:  begin flag = s1_a[WIDTH-1];    br_nxt = flag; end
      OP_BGEZ:  begin flag = !s1_a[WIDTH-1];   br_nxt = flag; end
      OP_PASSB: res_nxt = s1_b;
      OP_SLBI:  res_nxt = (s1_a << 8) | s1_b;
      default:  res_nxt = '0;
    endcase
    if (flag) res_nxt = {{(WIDTH-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      res      <= '0;
      br_take  <= 1'b0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      res      <= res_nxt;
      br_take  <= br_nxt;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign out_valid = s2_valid;

`ifdef ALU_PIPE_OFL_EN
  logic ofl_nxt, ofl_q;

  always_comb begin
    ofl_nxt = 1'b0;
    case (s1_op)
      OP_ADDC: ofl_nxt = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
      OP_SUB:  ofl_nxt = (s1_b[WIDTH-1] != s1_a[WIDTH-1]) && (dif[WIDTH-1] != s1_b[WIDTH-1]);
      default: ofl_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)           ofl_q <= 1'b0;
    else if (flush)    ofl_q <= ofl_q;
    else if (s1_adv)   ofl_q <= ofl_nxt;
  end

  assign ofl = ofl_q;
`else
  assign ofl = 1'b0;
`endif

endmodule
